// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory program loader.
//   OPCODE_W / LIT_W / INSTR_W : instruction word layout {opcode, literal}
//   MAX_WORDS                  : largest program, encoded as header byte 0
//   state_e                    : loader FSM states
package loader_pkg;

  localparam int OPCODE_W  = 7;
  localparam int LIT_W     = 8;
  localparam int INSTR_W   = OPCODE_W + LIT_W;
  localparam int MAX_WORDS = 256;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN   = 3'd1,
    ST_HI    = 3'd2,
    ST_LO    = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

endpackage

// File: rtl/imem_loader.sv
// Byte-stream program loader. Takes a length-prefixed byte stream
// (header N, then N {opcode, literal} byte pairs) and writes the
// assembled instruction words into instruction memory starting at
// address 0, holding the CPU while the load is in progress.
//
// Ports
//   clk, rst_n      system clock, async active-low reset
//   start           begin a load (only looked at in IDLE)
//   s_valid/s_data  input byte stream
//   s_ready         loader accepts a byte this cycle
//   im_we           one-cycle instruction memory write strobe
//   im_addr         write address
//   im_wdata        instruction word {opcode, literal}
//   cpu_hold        PC hold request
//   busy            FSM not idle
//   done            one-cycle pulse at end of a successful load
//   error           sticky malformed-stream flag
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; no bytes consumed
// LEN   | consume header byte (instruction count, 0 means 256)
// HI    | consume opcode byte; bit 7 set aborts with error
// LO    | consume literal byte, assemble the word
// WRITE | im_we strobe for the assembled word, advance or finish
// DONE  | one-cycle done pulse, then back to IDLE
module imem_loader #(
  parameter int ADDR_W   = 8,
  parameter int OPCODE_W = 7,
  parameter int LIT_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      s_valid,
  input  logic [7:0]                s_data,
  output logic                      s_ready,
  output logic                      im_we,
  output logic [ADDR_W-1:0]         im_addr,
  output logic [OPCODE_W+LIT_W-1:0] im_wdata,
  output logic                      cpu_hold,
  output logic                      busy,
  output logic                      done,
  output logic                      error
);
  import loader_pkg::*;

  // One extra bit so a full 256-word program count fits.
  localparam int CNT_W = $clog2(MAX_WORDS) + 1;

  state_e              state;
  logic [CNT_W-1:0]    word_cnt;
  logic [CNT_W-1:0]    word_total;
  logic [OPCODE_W-1:0] opcode;
  logic                xfer;

  // Handshake side is decoded from registered state only, never from s_valid.
  assign s_ready = (state == ST_LEN) || (state == ST_HI) || (state == ST_LO);
  assign xfer    = s_valid && s_ready;

  assign im_we   = (state == ST_WRITE);
  assign busy    = (state != ST_IDLE);
  assign done    = (state == ST_DONE);
  assign im_addr = word_cnt[ADDR_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      word_cnt   <= '0;
      word_total <= '0;
      opcode     <= '0;
      im_wdata   <= '0;
      cpu_hold   <= 1'b0;
      error      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_LEN;
            error    <= 1'b0;
            cpu_hold <= 1'b1;
            word_cnt <= '0;
          end
        end
        ST_LEN: begin
          if (xfer) begin
            word_total <= (s_data == 8'd0) ? CNT_W'(MAX_WORDS) : {1'b0, s_data};
            state      <= ST_HI;
          end
        end
        ST_HI: begin
          if (xfer) begin
            if (s_data[7]) begin
              // Abort leaves cpu_hold set: memory holds a partial program.
              error <= 1'b1;
              state <= ST_IDLE;
            end else begin
              opcode <= s_data[OPCODE_W-1:0];
              state  <= ST_LO;
            end
          end
        end
        ST_LO: begin
          if (xfer) begin
            im_wdata <= {opcode, s_data[LIT_W-1:0]};
            state    <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          // word_cnt is the index of the word being written, so the
          // last word is the one where index+1 reaches the total.
          if (word_cnt + CNT_W'(1) == word_total) begin
            cpu_hold <= 1'b0;
            state    <= ST_DONE;
          end else begin
            word_cnt <= word_cnt + CNT_W'(1);
            state    <= ST_HI;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic        im_we;
  logic [7:0]  im_addr;
  logic [14:0] im_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;

  imem_loader #(.ADDR_W(8), .OPCODE_W(7), .LIT_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .s_valid  (s_valid),
    .s_data   (s_data),
    .s_ready  (s_ready),
    .im_we    (im_we),
    .im_addr  (im_addr),
    .im_wdata (im_wdata),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]  wa_q[$];
  logic [14:0] wd_q[$];
  int          done_cnt = 0;
  logic        prev_we = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write/done monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (im_we) begin
      wa_q.push_back(im_addr);
      wd_q.push_back(im_wdata);
      chk("we_spacing", {31'd0, prev_we}, 32'd0);
    end
    if (done) done_cnt <= done_cnt + 1;
    prev_we <= im_we;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
    done_cnt = 0;
  endtask

  // Called at a negedge; returns at the negedge after the byte was taken.
  task automatic send_byte(input logic [7:0] b);
    int budget;
    budget  = 0;
    s_valid = 1'b1;
    s_data  = b;
    while (!s_ready && budget < 50) begin
      tick();
      budget++;
    end
    chk("byte_accept", {31'd0, s_ready}, 32'd1);
    tick();
    s_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", {31'd0, busy}, 32'd1);
    chk("start_hold", {31'd0, cpu_hold}, 32'd1);
    chk("start_ready", {31'd0, s_ready}, 32'd1);
  endtask

  task automatic wait_done();
    int budget;
    budget = 0;
    while (!done && budget < 50) begin
      tick();
      budget++;
    end
    chk("done_seen", {31'd0, done}, 32'd1);
    tick();
    chk("post_done_pulse", {31'd0, done}, 32'd0);
    chk("post_hold", {31'd0, cpu_hold}, 32'd0);
    chk("post_busy", {31'd0, busy}, 32'd0);
  endtask

  task automatic check_two(input string tag);
    chk({tag, "_nwr"}, wa_q.size(), 32'd2);
    chk({tag, "_ndone"}, done_cnt, 32'd1);
    if (wa_q.size() == 2) begin
      chk({tag, "_a0"}, {24'd0, wa_q[0]}, 32'h00);
      chk({tag, "_d0"}, {17'd0, wd_q[0]}, 32'h0105);
      chk({tag, "_a1"}, {24'd0, wa_q[1]}, 32'h01);
      chk({tag, "_d1"}, {17'd0, wd_q[1]}, 32'h02FF);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, {31'd0, s_ready}, 32'd0);
    chk({tag, "_we"}, {31'd0, im_we}, 32'd0);
    chk({tag, "_addr"}, {24'd0, im_addr}, 32'd0);
    chk({tag, "_wdata"}, {17'd0, im_wdata}, 32'd0);
    chk({tag, "_hold"}, {31'd0, cpu_hold}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_error"}, {31'd0, error}, 32'd0);
  endtask

  initial begin
    int bad;
    logic [7:0] stream2 [5];
    stream2[0] = 8'h02; stream2[1] = 8'h01; stream2[2] = 8'h05;
    stream2[3] = 8'h02; stream2[4] = 8'hFF;

    rst_n   = 1'b0;
    start   = 1'b0;
    s_valid = 1'b0;
    s_data  = 8'h00;
    tick();
    tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();
    chk("idle_ready", {31'd0, s_ready}, 32'd0);

    // N=2, continuous valid (HI bytes wait out the WRITE cycle)
    clear_log();
    do_start();
    for (int i = 0; i < 5; i++) send_byte(stream2[i]);
    wait_done();
    tick();
    check_two("n2");

    // Same stream with a gap cycle after every byte
    clear_log();
    do_start();
    for (int i = 0; i < 5; i++) begin
      send_byte(stream2[i]);
      tick();
    end
    wait_done();
    tick();
    check_two("bp");

    // start pulsed while in HI must be ignored
    clear_log();
    do_start();
    send_byte(8'h02);
    start = 1'b1;
    send_byte(8'h01);
    start = 1'b0;
    chk("hi_start_busy", {31'd0, busy}, 32'd1);
    for (int i = 2; i < 5; i++) send_byte(stream2[i]);
    wait_done();
    tick();
    check_two("hs");

    // 256-word program via header 0
    clear_log();
    do_start();
    send_byte(8'h00);
    for (int i = 0; i < 256; i++) begin
      send_byte({1'b0, i[6:0]});
      send_byte(i[7:0]);
    end
    wait_done();
    tick();
    chk("n256_nwr", wa_q.size(), 32'd256);
    chk("n256_ndone", done_cnt, 32'd1);
    if (wa_q.size() == 256) begin
      bad = 0;
      for (int i = 0; i < 256; i++)
        if (wa_q[i] !== i[7:0] || wd_q[i] !== {i[6:0], i[7:0]}) bad++;
      chk("n256_content", bad, 32'd0);
      chk("n256_last_a", {24'd0, wa_q[255]}, 32'hFF);
      chk("n256_last_d", {17'd0, wd_q[255]}, 32'h7FFF);
    end

    // Bad opcode byte aborts with sticky error, CPU stays held
    clear_log();
    do_start();
    send_byte(8'h01);
    send_byte(8'h80);
    chk("bad_error", {31'd0, error}, 32'd1);
    chk("bad_busy", {31'd0, busy}, 32'd0);
    chk("bad_hold", {31'd0, cpu_hold}, 32'd1);
    chk("bad_ready", {31'd0, s_ready}, 32'd0);
    tick();
    tick();
    chk("bad_error_sticky", {31'd0, error}, 32'd1);
    chk("bad_nwr", wa_q.size(), 32'd0);

    // Recovery load, N=1, also checks best-case latency
    do_start();
    chk("rec_error_clr", {31'd0, error}, 32'd0);
    send_byte(8'h01);
    send_byte(8'h33);
    send_byte(8'h44);
    chk("rec_we", {31'd0, im_we}, 32'd1);
    chk("rec_addr", {24'd0, im_addr}, 32'h00);
    chk("rec_wdata", {17'd0, im_wdata}, 32'h3344);
    tick();
    chk("rec_done_cycle5", {31'd0, done}, 32'd1);
    tick();
    chk("rec_hold", {31'd0, cpu_hold}, 32'd0);
    chk("rec_error", {31'd0, error}, 32'd0);

    // Reset asserted during LO: asynchronous return, no write
    clear_log();
    do_start();
    send_byte(8'h01);
    send_byte(8'h7F);
    s_valid = 1'b1;
    s_data  = 8'h55;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    tick();
    tick();
    s_valid = 1'b0;
    rst_n   = 1'b1;
    tick();
    chk("midrst_nwr", wa_q.size(), 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
